// File: rtl/pointer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pointer_seq_pkg
//  Description : Shared opcode/state encodings and wait-state limit for the
//                pointer-pair sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pointer_seq_pkg;

    // Opcodes presented on the op bus; 5..7 are illegal.
    typedef enum logic [2:0] {
        OP_FETCH    = 3'd0,
        OP_READ_DP  = 3'd1,
        OP_LOAD_DP  = 3'd2,
        OP_STORE_DP = 3'd3,
        OP_SWAP     = 3'd4
    } op_e;

    // Sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F_ADDR = 4'd1,
        ST_F_INC  = 4'd2,
        ST_R_ADDR = 4'd3,
        ST_L_LO   = 4'd4,
        ST_L_HI   = 4'd5,
        ST_S_LO   = 4'd6,
        ST_S_HI   = 4'd7,
        ST_SWAP   = 4'd8
    } state_e;

    // Wait-counter value at which an unanswered memory access is abandoned.
    localparam logic [3:0] WAIT_MAX = 4'd15;

endpackage : pointer_seq_pkg
`default_nettype wire

// File: rtl/pointer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pointer_sequencer
//  Description : Sequences the strobes of a pair of address pointers (IP and
//                DP, exchangeable through 'selector') for instruction fetch,
//                data read, data-pointer load/store and pointer swap.
//                All strobes, cnt, done and err are registered so they are
//                glitch-free; active-low strobes idle high.
//
//  Ports
//    clk, rst          : clock, asynchronous active-high reset
//    op, op_valid      : opcode and its valid; op_ready high only in IDLE
//    di                : memory data, captured by FETCH (ir) / READ_DP (rdata)
//    mem_rdy           : memory ready (wait-state build only)
//    oe_addr_ip/dp     : active-low address output enables of IP / DP
//    oe_dl, oe_dh      : active-low DP low/high byte output enables
//    we_l, we_h        : active-low DP low/high byte write enables
//    cnt               : IP increment pulse
//    selector          : 0 = pointer A is IP, 1 = pointer B is IP
//    ir, rdata         : captured fetch / read bytes
//    done, err         : completion pulse, err qualifies done
//
//  Configuration
//    POINTER_SEQ_WAIT_EN : when defined, F_ADDR/R_ADDR stall on mem_rdy=0 and
//                          abort with done+err once the wait counter would
//                          reach WAIT_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module pointer_sequencer
    import pointer_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] op,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [7:0] di,
    input  logic       mem_rdy,
    output logic       oe_addr_ip,
    output logic       oe_addr_dp,
    output logic       oe_dl,
    output logic       oe_dh,
    output logic       we_l,
    output logic       we_h,
    output logic       cnt,
    output logic       selector,
    output logic [7:0] ir,
    output logic [7:0] rdata,
    output logic       done,
    output logic       err
);

    state_e     r_state;
    logic       r_op_ready;
    logic       r_oe_addr_ip;
    logic       r_oe_addr_dp;
    logic       r_oe_dl;
    logic       r_oe_dh;
    logic       r_we_l;
    logic       r_we_h;
    logic       r_cnt;
    logic       r_selector;
    logic [7:0] r_ir;
    logic [7:0] r_rdata;
    logic       r_done;
    logic       r_err;

    // Memory-access completion qualifiers for F_ADDR / R_ADDR.
    logic       w_complete;
    logic       w_timeout;

`ifdef POINTER_SEQ_WAIT_EN
    logic [3:0] r_wait;

    assign w_complete = mem_rdy;
    // Abort on the wait cycle that would carry the counter to WAIT_MAX.
    assign w_timeout  = !mem_rdy && (r_wait == (WAIT_MAX - 4'd1));
`else
    logic       w_unused_mem_rdy;

    assign w_unused_mem_rdy = mem_rdy;
    assign w_complete       = 1'b1;
    assign w_timeout        = 1'b0;
`endif

    // Outputs are computed one edge ahead so each is a flop output that is
    // valid for exactly the cycles the FSM spends in the owning state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op_ready   <= 1'b0;
            r_oe_addr_ip <= 1'b1;
            r_oe_addr_dp <= 1'b1;
            r_oe_dl      <= 1'b1;
            r_oe_dh      <= 1'b1;
            r_we_l       <= 1'b1;
            r_we_h       <= 1'b1;
            r_cnt        <= 1'b0;
            r_selector   <= 1'b0;
            r_ir         <= 8'h00;
            r_rdata      <= 8'h00;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef POINTER_SEQ_WAIT_EN
            r_wait       <= 4'd0;
`endif
        end else begin
            // Pulses and strobes default to inactive every cycle.
            r_op_ready   <= 1'b0;
            r_oe_addr_ip <= 1'b1;
            r_oe_addr_dp <= 1'b1;
            r_oe_dl      <= 1'b1;
            r_oe_dh      <= 1'b1;
            r_we_l       <= 1'b1;
            r_we_h       <= 1'b1;
            r_cnt        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (op_valid && r_op_ready) begin
                        case (op)
                            OP_FETCH: begin
                                r_state      <= ST_F_ADDR;
                                r_oe_addr_ip <= 1'b0;
                            end
                            OP_READ_DP: begin
                                r_state      <= ST_R_ADDR;
                                r_oe_addr_dp <= 1'b0;
                            end
                            OP_LOAD_DP: begin
                                r_state <= ST_L_LO;
                                r_we_l  <= 1'b0;
                            end
                            OP_STORE_DP: begin
                                r_state <= ST_S_LO;
                                r_oe_dl <= 1'b0;
                            end
                            OP_SWAP: begin
                                r_state <= ST_SWAP;
                                r_done  <= 1'b1;
                            end
                            default: begin
                                // Illegal op: stay in IDLE, report error in the
                                // next cycle, during which op_ready is low.
                                r_done <= 1'b1;
                                r_err  <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_op_ready <= 1'b1;
                    end
                end

                ST_F_ADDR: begin
                    if (w_complete) begin
                        r_ir    <= di;
                        r_state <= ST_F_INC;
                        r_cnt   <= 1'b1;
                        r_done  <= 1'b1;
`ifdef POINTER_SEQ_WAIT_EN
                        r_wait  <= 4'd0;
`endif
                    end else if (w_timeout) begin
                        // Abandon the fetch: no capture, no IP increment.
                        r_state    <= ST_IDLE;
                        r_op_ready <= 1'b1;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
`ifdef POINTER_SEQ_WAIT_EN
                        r_wait     <= 4'd0;
`endif
                    end else begin
                        r_oe_addr_ip <= 1'b0;
`ifdef POINTER_SEQ_WAIT_EN
                        r_wait       <= r_wait + 4'd1;
`endif
                    end
                end

                ST_F_INC: begin
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b1;
                end

                ST_R_ADDR: begin
                    if (w_complete) begin
                        r_rdata    <= di;
                        r_state    <= ST_IDLE;
                        r_op_ready <= 1'b1;
                        r_done     <= 1'b1;
`ifdef POINTER_SEQ_WAIT_EN
                        r_wait     <= 4'd0;
`endif
                    end else if (w_timeout) begin
                        r_state    <= ST_IDLE;
                        r_op_ready <= 1'b1;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
`ifdef POINTER_SEQ_WAIT_EN
                        r_wait     <= 4'd0;
`endif
                    end else begin
                        r_oe_addr_dp <= 1'b0;
`ifdef POINTER_SEQ_WAIT_EN
                        r_wait       <= r_wait + 4'd1;
`endif
                    end
                end

                ST_L_LO: begin
                    r_state <= ST_L_HI;
                    r_we_h  <= 1'b0;
                    r_done  <= 1'b1;
                end

                ST_L_HI: begin
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b1;
                end

                ST_S_LO: begin
                    r_state <= ST_S_HI;
                    r_oe_dh <= 1'b0;
                    r_done  <= 1'b1;
                end

                ST_S_HI: begin
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b1;
                end

                ST_SWAP: begin
                    r_selector <= ~r_selector;
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready   = r_op_ready;
    assign oe_addr_ip = r_oe_addr_ip;
    assign oe_addr_dp = r_oe_addr_dp;
    assign oe_dl      = r_oe_dl;
    assign oe_dh      = r_oe_dh;
    assign we_l       = r_we_l;
    assign we_h       = r_we_h;
    assign cnt        = r_cnt;
    assign selector   = r_selector;
    assign ir         = r_ir;
    assign rdata      = r_rdata;
    assign done       = r_done;
    assign err        = r_err;

endmodule : pointer_sequencer
`default_nettype wire

// File: tb/tb_pointer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pointer_sequencer
//  Description : Scoreboard bench for pointer_sequencer. Stimulus pushes the
//                expected per-cycle strobe pattern, err and captured data;
//                the monitor records strobes from accept to done and compares.
//                Pattern bits: {cnt, dh, dl, we_h, we_l, addr_dp, addr_ip}
//                as active-high flags, one entry per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pointer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] di;
    logic       mem_rdy;
    logic       oe_addr_ip, oe_addr_dp, oe_dl, oe_dh, we_l, we_h;
    logic       cnt, selector, done, err;
    logic [7:0] ir, rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             err;
        logic [7:0]       ir;
        logic [7:0]       rdata;
        logic             sel;
        int               len;
        logic [15:0][6:0] pat;
    } exp_t;

    exp_t sb[$];

    pointer_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .di         (di),
        .mem_rdy    (mem_rdy),
        .oe_addr_ip (oe_addr_ip),
        .oe_addr_dp (oe_addr_dp),
        .oe_dl      (oe_dl),
        .oe_dh      (oe_dh),
        .we_l       (we_l),
        .we_h       (we_h),
        .cnt        (cnt),
        .selector   (selector),
        .ir         (ir),
        .rdata      (rdata),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] active_vec();
        return {cnt, ~oe_dh, ~oe_dl, ~we_h, ~we_l, ~oe_addr_dp, ~oe_addr_ip};
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic             collecting;
        logic             pend;
        int               len;
        logic [15:0][6:0] pat;
        exp_t             e;
        collecting = 1'b0;
        pend       = 1'b0;
        len        = 0;
        pat        = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                collecting = 1'b0;
                pend       = 1'b0;
            end else begin
                if (pend) begin
                    chk("ir", ir, e.ir);
                    chk("rdata", rdata, e.rdata);
                    chk("selector", selector, e.sel);
                    pend = 1'b0;
                end
                chk("strobe_conflict",
                    (!oe_addr_ip && !oe_addr_dp) ||
                    ((!we_l || !we_h) && (!oe_dl || !oe_dh)), 1'b0);
                if (collecting) begin
                    if (len < 16) pat[len] = active_vec();
                    len++;
                    if (done) begin
                        collecting = 1'b0;
                        if (sb.size() == 0) begin
                            chk("unexpected_done", done, 1'b0);
                        end else begin
                            e = sb.pop_front();
                            chk("latency", len, e.len);
                            chk("strobe_pattern", pat, e.pat);
                            chk("err", err, e.err);
                            pend = 1'b1;
                        end
                    end else if (len > 20) begin
                        collecting = 1'b0;
                        chk("done_timeout", done, 1'b1);
                    end
                end else begin
                    chk("idle_done", done, 1'b0);
                end
                if (op_valid && op_ready) begin
                    collecting = 1'b1;
                    len        = 0;
                    pat        = '0;
                end
            end
        end
    end

    // Expected pattern: n cycles of 'a' followed by the done cycle 'b'.
    task automatic push(input logic e_err, input logic [7:0] e_ir, input logic [7:0] e_rd,
                        input logic e_sel, input int n, input logic [6:0] a, input logic [6:0] b);
        exp_t e;
        e.err   = e_err;
        e.ir    = e_ir;
        e.rdata = e_rd;
        e.sel   = e_sel;
        e.pat   = '0;
        for (int i = 0; i < n; i++) e.pat[i] = a;
        e.pat[n] = b;
        e.len   = n + 1;
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] d);
        int n = 0;
        while (!op_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!op_ready) chk("op_ready_timeout", op_ready, 1'b1);
        op       = o;
        di       = d;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        op       = 3'd0;
        op_valid = 1'b0;
        di       = 8'h00;
        mem_rdy  = 1'b1;

        // Reset state: {op_ready, 6 strobes, cnt, selector, done, err, ir, rdata}
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",
            {op_ready, oe_addr_ip, oe_addr_dp, oe_dl, oe_dh, we_l, we_h,
             cnt, selector, done, err, ir, rdata},
            {1'b0, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("op_ready_after_reset", op_ready, 1'b1);

        // FETCH A5: addr_ip one cycle, then cnt with done.
        push(1'b0, 8'hA5, 8'h00, 1'b0, 1, 7'h01, 7'h40);
        send(3'd0, 8'hA5); drain();
        // LOAD_DP: we_l then we_h.
        push(1'b0, 8'hA5, 8'h00, 1'b0, 1, 7'h04, 7'h08);
        send(3'd2, 8'h00); drain();
        // STORE_DP: oe_dl then oe_dh.
        push(1'b0, 8'hA5, 8'h00, 1'b0, 1, 7'h10, 7'h20);
        send(3'd3, 8'h00); drain();
        // SWAP, FETCH 3C, SWAP: selector 0 -> 1 -> 0.
        push(1'b0, 8'hA5, 8'h00, 1'b1, 0, 7'h00, 7'h00);
        send(3'd4, 8'h00); drain();
        push(1'b0, 8'h3C, 8'h00, 1'b1, 1, 7'h01, 7'h40);
        send(3'd0, 8'h3C); drain();
        push(1'b0, 8'h3C, 8'h00, 1'b0, 0, 7'h00, 7'h00);
        send(3'd4, 8'h00); drain();
        // READ_DP 5A: addr_dp one cycle, done the cycle after; ir unchanged.
        push(1'b0, 8'h3C, 8'h5A, 1'b0, 1, 7'h02, 7'h00);
        send(3'd1, 8'h5A); drain();
        // Illegal opcodes 6 and 7: done+err next cycle, no strobes.
        push(1'b1, 8'h3C, 8'h5A, 1'b0, 0, 7'h00, 7'h00);
        send(3'd6, 8'hFF); drain();
        push(1'b1, 8'h3C, 8'h5A, 1'b0, 0, 7'h00, 7'h00);
        send(3'd7, 8'hFF); drain();

        // Reset during L_HI: we_h released immediately, no done.
        send(3'd2, 8'h00);
        @(posedge clk); #2;
        chk("in_l_hi_we_h", we_h, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_strobes", {we_l, we_h, done, cnt, op_ready}, 5'b11000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_abort_ir", ir, 8'h00);
        chk("post_abort_ready", op_ready, 1'b1);

        push(1'b0, 8'h11, 8'h00, 1'b0, 1, 7'h01, 7'h40);
        send(3'd0, 8'h11); drain();

`ifdef POINTER_SEQ_WAIT_EN
        // READ_DP with 3 wait cycles: addr_dp low 4 cycles.
        push(1'b0, 8'h11, 8'h7E, 1'b0, 4, 7'h02, 7'h00);
        mem_rdy = 1'b0;
        send(3'd1, 8'h7E);
        repeat (3) begin
            @(posedge clk); #1;
        end
        mem_rdy = 1'b1;
        drain();
        // READ_DP timeout: 15 wait cycles, then done+err, rdata kept.
        push(1'b1, 8'h11, 8'h7E, 1'b0, 15, 7'h02, 7'h00);
        mem_rdy = 1'b0;
        send(3'd1, 8'h99); drain();
        mem_rdy = 1'b1;
        // FETCH timeout: no capture and no cnt.
        push(1'b1, 8'h11, 8'h7E, 1'b0, 15, 7'h01, 7'h00);
        mem_rdy = 1'b0;
        send(3'd0, 8'h55); drain();
        mem_rdy = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pointer_sequencer
`default_nettype wire
